// File: rtl/spi_reg_slave.sv
// SPI slave (mode set by CPOL/CPHA) fronting a byte-wide register bank with address auto-increment.
// Optional: define SPI_ERR_CNT_EN for a saturating protocol error counter at address 0xFF.
//
// state   | meaning
// IDLE    | waiting for csn falling edge (only after csn has been seen high)
// OPCODE  | shifting in the opcode byte
// ADDR    | shifting in the start address
// DATA    | write or read data bytes, address auto-increments
// DISCARD | unknown opcode, bits ignored until csn high
module spi_reg_slave #(
    parameter int         NUM_REGS    = 16,
    parameter bit         CPOL        = 1'b0,
    parameter bit         CPHA        = 1'b0,
    parameter logic [7:0] RST_VAL     = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sclk_i,
    input  logic                  csn_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_stb_o,
    output logic [7:0]            wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  busy_o
);
    localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS = 9'(NUM_REGS);
    localparam logic [7:0] OP_WR = 8'h40;
    localparam logic [7:0] OP_RD = 8'h41;

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, DISCARD} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync, vld_sync;
    logic       sclk_s, csn_s, mosi_s, sclk_d, csn_d, armed_q;
    logic       sclk_chg, lead_edge, trail_edge, smp_edge, shf_edge;
    logic       in_frame, byte_done, op_valid;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_sr_q;
    logic [7:0] rx_byte, addr_q, tx_sr_q, rd_sel, rd_data;
    logic       is_rd_q, miso_q;
    logic [7:0] regs_q [NUM_REGS];

`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_inc, err_clr;
`endif

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // vld_sync marks when the synchroniser holds real samples rather than reset values,
    // so a frame already in flight at reset release is never mistaken for a new one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            csn_sync  <= '1;
            mosi_sync <= '0;
            vld_sync  <= '0;
            sclk_d    <= CPOL;
            csn_d     <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            csn_d     <= csn_s;
            if (vld_sync[SYNC_STAGES-1] && csn_s) armed_q <= 1'b1;
        end
    end

    assign sclk_chg   = (sclk_s != sclk_d) && !csn_s;
    assign lead_edge  = sclk_chg && (sclk_s != CPOL);
    assign trail_edge = sclk_chg && (sclk_s == CPOL);
    assign smp_edge   = CPHA ? trail_edge : lead_edge;
    assign shf_edge   = CPHA ? lead_edge : trail_edge;

    assign in_frame  = (state_q == OPCODE) || (state_q == ADDR) || (state_q == DATA);
    assign rx_byte   = {rx_sr_q, mosi_s};
    assign byte_done = in_frame && smp_edge && (bit_cnt_q == 3'd7);
    assign op_valid  = (rx_byte == OP_WR) || (rx_byte == OP_RD);
    assign busy_o    = !csn_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        miso_oe_o = 1'b0;
        case (state_q)
            IDLE:    if (armed_q && csn_d && !csn_s) state_d = OPCODE;
            OPCODE:  if (byte_done) state_d = op_valid ? ADDR : DISCARD;
            ADDR:    if (byte_done) state_d = DATA;
            DATA:    miso_oe_o = is_rd_q && !csn_s;
            default: state_d = state_q;
        endcase
        if ((state_q != IDLE) && csn_s) state_d = IDLE;
    end

    assign miso_o = miso_oe_o & miso_q;

    // Read source: start address at the end of ADDR, next address during DATA.
    always_comb begin
        rd_sel  = (state_q == ADDR) ? rx_byte : addr_q + 8'd1;
        rd_data = 8'h00;
        if ({1'b0, rd_sel} < NREGS) rd_data = regs_q[rd_sel[AW-1:0]];
`ifdef SPI_ERR_CNT_EN
        else if (rd_sel == 8'hFF) rd_data = err_cnt_q;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            addr_q    <= '0;
            is_rd_q   <= 1'b0;
            tx_sr_q   <= '0;
            miso_q    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RST_VAL;
        end else begin
            wr_stb_o <= 1'b0;
            if (!in_frame) bit_cnt_q <= '0;
            if (state_q == IDLE) miso_q <= 1'b0;
            if (in_frame && smp_edge) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_sr_q   <= rx_byte[6:0];
            end
            if (byte_done) begin
                if (state_q == OPCODE) is_rd_q <= (rx_byte == OP_RD);
                if (state_q == ADDR) addr_q <= rx_byte;
                if (state_q == DATA) addr_q <= addr_q + 8'd1;
                if (((state_q == ADDR) || (state_q == DATA)) && is_rd_q) begin
                    tx_sr_q <= CPHA ? rd_data : {rd_data[6:0], 1'b0};
                    if (!CPHA) miso_q <= rd_data[7];
                end
                if ((state_q == DATA) && !is_rd_q && ({1'b0, addr_q} < NREGS)) begin
                    regs_q[addr_q[AW-1:0]] <= rx_byte;
                    wr_stb_o  <= 1'b1;
                    wr_addr_o <= addr_q;
                    wr_data_o <= rx_byte;
                end
            end
            // With CPHA=0 the MSB is already out after the load, so the first shift edge is skipped.
            if (shf_edge && (state_q == DATA) && is_rd_q && (CPHA || (bit_cnt_q != 3'd0))) begin
                miso_q  <= tx_sr_q[7];
                tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
        end
    end

`ifdef SPI_ERR_CNT_EN
    assign err_inc = ((state_q == OPCODE) && byte_done && !op_valid) ||
                     (in_frame && csn_s && !csn_d && (bit_cnt_q != 3'd0));
    assign err_clr = (state_q == DATA) && byte_done && !is_rd_q && (addr_q == 8'hFF);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                               err_cnt_q <= '0;
        else if (err_clr)                        err_cnt_q <= '0;
        else if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
`endif

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) regs_o[8*k +: 8] = regs_q[k];
    end
endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
Parametrised SPI slave with an internal byte-wide register bank. It is the successor to the fixed two-byte SPI test slaves. It oversamples sclk/csn/mosi in the system clock domain and decodes a frame of opcode byte, address byte and N data bytes, with address auto-increment. SPI mode (CPOL/CPHA) and register count are configurable. Register contents drive PL control logic through a flat output bus.

Parameters:
NUM_REGS, 16, number of 8-bit registers (1..255); addresses 0..NUM_REGS-1
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
RST_VAL, 8'h00, reset value of every register
SYNC_STAGES, 2, synchroniser depth on sclk_i/csn_i/mosi_i (>=2)

Ports:
clk  in  1  system clock (sclk must be <= clk/8)
rstn  in  1  asynchronous active-low reset
sclk_i  in  1  SPI clock, asynchronous
csn_i  in  1  chip select, active low, asynchronous
mosi_i  in  1  serial data in, MSB first
miso_o  out  1  serial data out, MSB first
miso_oe_o  out  1  1 while csn is low (synchronised) and a read is in progress
regs_o  out  NUM_REGS*8  register bank, reg k at [8k+7:8k]
wr_stb_o  out  1  one-clk pulse per register written
wr_addr_o  out  8  address of the write, valid with wr_stb_o
wr_data_o  out  8  data of the write, valid with wr_stb_o
busy_o  out  1  frame in progress (synchronised csn low)

Behaviour:
- Clock/reset: one clock (clk); rstn asynchronous, active low.
- Reset values: all regs = RST_VAL; miso_o=0, miso_oe_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0; FSM = IDLE.
- Inputs pass through SYNC_STAGES flops. Edge detection compares the last two synchronised sclk samples. Leading edge = transition away from CPOL. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- sclk edges are ignored while synchronised csn is high.
- FSM states: IDLE, OPCODE, ADDR, DATA, DISCARD.
- IDLE -> OPCODE on csn falling (synchronised). Bit counter is cleared.
- OPCODE: 8 sample edges shift mosi into the shift register. Then 0x40 = write and 0x41 = read, both -> ADDR. Any other opcode -> DISCARD.
- ADDR: 8 bits are latched into the address pointer. For a read, reg[addr] is loaded into the tx shift register at byte completion (0x00 if addr >= NUM_REGS). -> DATA.
- DATA write: each completed byte writes reg[addr] when addr < NUM_REGS. wr_stb_o pulses 1 clk, one cycle after the 8th sample edge is detected, with wr_addr_o/wr_data_o. Writes to addr >= NUM_REGS are dropped, with no strobe. addr then increments mod 256.
- DATA read, miso timing:
  - CPHA=0: MSB is presented on miso_o the cycle after the load; each shift edge presents the next bit.
  - CPHA=1: each leading edge presents the next bit, starting with the MSB.
  - After 8 bits, addr increments and the next register is loaded.
  - miso_oe_o=1 throughout DATA-read. miso_o=0 whenever miso_oe_o=0.
- DISCARD: all bits ignored until csn high.
- csn rising in any state -> IDLE within SYNC_STAGES+1 clk. A partial byte is discarded (no write, no strobe). miso_oe_o drops in the same cycle.
- If a write and the incoming readback target the same register, the write completes first; the next read load sees the new value.
- rstn asserted mid-frame: immediate reset. After release, FSM stays IDLE until synchronised csn is seen high, so the remainder of an in-flight frame is ignored.
- busy_o = synchronised csn low, any state.

Optional Feature:
SPI_ERR_CNT_EN: adds an 8-bit saturating error counter. It increments on bad opcode and on csn rising with a partial byte (bit count != 0). It is read-only at address 0xFF; a read of 0xFF returns the counter. A write of any data to 0xFF clears it (no wr_stb_o). Without the macro there is no counter, and address 0xFF behaves as any address >= NUM_REGS (reads 0x00, writes dropped).

Test Plan:
- Mode 0, clk 100 MHz, sclk 12.5 MHz: frame 0x40,0x01,0xA5 -> single wr_stb_o with wr_addr_o=0x01, wr_data_o=0xA5; regs_o[15:8]=0xA5.
- Then frame 0x41,0x01,0x00,0x00 -> miso returns 0xA5 then reg2 (RST_VAL 0x00); miso_oe_o high only during the 16 data bits.
- Burst write 0x40,0x0E,0x11,0x22,0x33 with NUM_REGS=16 -> reg14=0x11, reg15=0x22, third byte dropped (address 0x10), exactly 2 strobes.
- Repeat the first two scenarios for CPOL/CPHA = (0,1), (1,0), (1,1) -> identical register and miso data.
- Bad opcode 0x55 followed by 16 bits -> no strobe, miso_oe_o stays 0; with SPI_ERR_CNT_EN, a read of 0xFF returns 0x01.
- csn raised after 4 bits of the data byte in a write, and rstn pulsed mid-frame in a separate run -> no write and no strobe; all regs = RST_VAL after reset; the next clean frame works.
